playback_controller: RTL and testbench
======================================

# playback_controller

Sequencing controller for the music player's elapsed-time Timer and track selection. It turns play/pause/stop/next/prev button pulses into a playback state machine. It generates the one-second count enable from the system clock and issues synchronous clear and count-enable controls to the Timer. It detects end-of-track by comparing the Timer's BCD digits with the current track length, then advances, wraps or stops.

## Interface
Parameters:
- TICK_DIV, 50_000_000, system-clock cycles per elapsed second (≥2)
- NUM_TRACKS, 4, number of tracks (≥1); TRK_W = max(1, clog2(NUM_TRACKS))
- LOOP, 0, 1 = wrap from last track to track 0 at end-of-track; 0 = stop at end of last track

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- btn_play_pause  in  1  one-cycle pulse, toggles play/pause
- btn_stop  in  1  one-cycle pulse
- btn_next  in  1  one-cycle pulse
- btn_prev  in  1  one-cycle pulse
- len_s0, len_s1, len_m0  in  4 each  BCD length of current track (from track ROM, indexed by track_idx)
- tm_s0, tm_s1, tm_m0  in  4 each  Timer's current BCD digits
- sec_tick  out  1  one-cycle count-enable pulse per elapsed second, PLAYING only
- timer_count  out  1  Timer count enable (1 in PLAYING)
- timer_clear  out  1  one-cycle synchronous Timer clear
- track_idx  out  TRK_W  current track
- playing  out  1  1 in PLAYING
- state  out  2  encoded FSM state

## Operation
- States: STOPPED=0, PLAYING=1, PAUSED=2, ADVANCE=3.
- Reset values: state=STOPPED, track_idx=0, prescaler=0, sec_tick=0, timer_count=0, timer_clear=1 (held while reset low and for the first cycle after release), playing=0.
- Command priority within one cycle: stop > next/prev (next wins if both) > play_pause > end-of-track.
- STOPPED:
  - play_pause → PLAYING.
  - next/prev changes track_idx: modulo NUM_TRACKS, regardless of LOOP. Pulses timer_clear.
- PLAYING:
  - play_pause → PAUSED.
  - stop → STOPPED with timer_clear and prescaler cleared.
  - next/prev → ADVANCE with direction latched.
  - end-of-track → ADVANCE with direction = next.
- PAUSED:
  - play_pause → PLAYING.
  - stop → STOPPED with clear.
  - next/prev → track change and timer_clear, staying PAUSED.
  - The prescaler holds its value, so the fraction of the current second is preserved.
- ADVANCE (exactly one cycle):
  - timer_clear=1, prescaler cleared, track_idx updated.
  - Next wraps modulo NUM_TRACKS.
  - Prev from 0 goes to NUM_TRACKS-1.
  - Auto-advance from the last track with LOOP=0 → STOPPED with track_idx=0.
  - Otherwise → PLAYING.
- End-of-track: in PLAYING, when {tm_m0,tm_s1,tm_s0} == {len_m0,len_s1,len_s0}, all 12 bits. A zero-length track ends on the first PLAYING cycle.
- Prescaler: width clog2(TICK_DIV); counts 0..TICK_DIV-1 only in PLAYING. sec_tick=1 on the cycle the count equals TICK_DIV-1; the count then wraps to 0.
- Button pulses in ADVANCE are ignored.

## Timing
- All outputs are registered and take effect on the clock edge after the triggering input.
- First sec_tick comes TICK_DIV cycles after entering PLAYING from a cleared prescaler.
- The Timer updates its digits one cycle after sec_tick, and the equality compare uses those updated digits. ADVANCE therefore occurs at most 2 cycles after the tick that reaches the track length.
- sec_tick is never asserted in the same cycle as timer_clear.
- Reset mid-operation: outputs return to reset values asynchronously; no tick is emitted until PLAYING is re-entered.

## Structure
- Shared package/include: state encodings (STOPPED/PLAYING/PAUSED/ADVANCE), 4-bit BCD digit width, 12-bit packed time type.
- One sub-module, tick_divider (params TICK_DIV; ports clk, reset, en, clr, tick), holds the prescaler.
- FSM, track index and end-of-track compare stay in playback_controller.

## Test plan
Benches use TICK_DIV=4, NUM_TRACKS=3 and a behavioural Timer model.
- Release reset, pulse play_pause → PLAYING next cycle; sec_tick on cycles 4, 8, 12 after entry; timer_count=1.
- Play 6 ticks, pause for 10 cycles, resume → tick spacing is preserved (no lost or extra tick); the Timer reads 0:06 at pause and continues to 0:07.
- Track 0 length 0:03, LOOP=0 → after the tick to 0:03: ADVANCE for one cycle, timer_clear=1, track_idx=1, back in PLAYING. On the last track (idx 2) end → STOPPED, track_idx=0.
- LOOP=1, end of track 2 → track_idx=0, PLAYING.
- Same cycle btn_stop, btn_next and btn_play_pause while PLAYING → STOPPED, track_idx unchanged, timer_clear pulse.
- Drop reset low mid-count (prescaler=2, track 1) → immediately state=0, track_idx=0, timer_clear=1; after release, no sec_tick until play_pause.

Source files
------------

// File: rtl/playback_controller_pkg.sv
// rtl/playback_controller_pkg.sv - shared state encodings and BCD time types
package playback_controller_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2,
    ADVANCE = 2'd3
  } pb_state_t;

  localparam int BCD_W = 4;

  typedef logic [3*BCD_W-1:0] bcd_time_t;

  function automatic bcd_time_t pack_time(input logic [BCD_W-1:0] m0,
                                          input logic [BCD_W-1:0] s1,
                                          input logic [BCD_W-1:0] s0);
    return {m0, s1, s0};
  endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - one-second prescaler producing a registered count-enable tick
module tick_divider #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // With en low the count holds, so a pause keeps the fraction of the second.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + 1'b1;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/playback_controller.sv
// rtl/playback_controller.sv - play/pause/stop/track sequencing for the elapsed-time Timer
module playback_controller
  import playback_controller_pkg::*;
#(
  parameter int  TICK_DIV   = 50_000_000,
  parameter int  NUM_TRACKS = 4,
  parameter bit  LOOP       = 1'b0,
  localparam int TRK_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_play_pause,
  input  logic             btn_stop,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic [BCD_W-1:0] len_s0,
  input  logic [BCD_W-1:0] len_s1,
  input  logic [BCD_W-1:0] len_m0,
  input  logic [BCD_W-1:0] tm_s0,
  input  logic [BCD_W-1:0] tm_s1,
  input  logic [BCD_W-1:0] tm_m0,
  output logic             sec_tick,
  output logic             timer_count,
  output logic             timer_clear,
  output logic [TRK_W-1:0] track_idx,
  output logic             playing,
  output logic [1:0]       state
);

  localparam logic [TRK_W-1:0] LAST_TRK = TRK_W'(NUM_TRACKS - 1);

  pb_state_t        cur, nxt;
  logic [TRK_W-1:0] idx_nxt;
  logic             clear_nxt;
  logic             adv_stop, adv_stop_nxt;
  logic             eot;
  logic             presc_en, presc_clr;

  function automatic logic [TRK_W-1:0] trk_step(input logic [TRK_W-1:0] idx, input logic fwd);
    if (fwd) return (idx == LAST_TRK) ? '0 : idx + 1'b1;
    return (idx == '0) ? LAST_TRK : idx - 1'b1;
  endfunction

  // Command decode; priority is stop, then next/prev, then play_pause, then end-of-track.
  always_comb begin
    nxt          = cur;
    idx_nxt      = track_idx;
    clear_nxt    = 1'b0;
    adv_stop_nxt = adv_stop;
    eot          = pack_time(tm_m0, tm_s1, tm_s0) == pack_time(len_m0, len_s1, len_s0);
    case (cur)
      STOPPED: begin
        if (!btn_stop && (btn_next || btn_prev)) begin
          idx_nxt   = trk_step(track_idx, btn_next);
          clear_nxt = 1'b1;
        end else if (!btn_stop && btn_play_pause) begin
          nxt = PLAYING;
        end
      end
      PLAYING: begin
        if (btn_stop) begin
          nxt       = STOPPED;
          clear_nxt = 1'b1;
        end else if (btn_next || btn_prev) begin
          nxt          = ADVANCE;
          clear_nxt    = 1'b1;
          idx_nxt      = trk_step(track_idx, btn_next);
          adv_stop_nxt = 1'b0;
        end else if (btn_play_pause) begin
          nxt = PAUSED;
        end else if (eot) begin
          nxt          = ADVANCE;
          clear_nxt    = 1'b1;
          idx_nxt      = trk_step(track_idx, 1'b1);
          adv_stop_nxt = !LOOP && (track_idx == LAST_TRK);
        end
      end
      PAUSED: begin
        if (btn_stop) begin
          nxt       = STOPPED;
          clear_nxt = 1'b1;
        end else if (btn_next || btn_prev) begin
          idx_nxt   = trk_step(track_idx, btn_next);
          clear_nxt = 1'b1;
        end else if (btn_play_pause) begin
          nxt = PLAYING;
        end
      end
      ADVANCE: nxt = adv_stop ? STOPPED : PLAYING;
      default: nxt = STOPPED;
    endcase
  end

  // Counting only while staying in PLAYING keeps sec_tick apart from timer_clear.
  assign presc_en  = (cur == PLAYING) && (nxt == PLAYING);
  assign presc_clr = clear_nxt || (cur == ADVANCE);

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (sec_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur         <= STOPPED;
      track_idx   <= '0;
      timer_clear <= 1'b1;
      timer_count <= 1'b0;
      playing     <= 1'b0;
      adv_stop    <= 1'b0;
    end else begin
      cur         <= nxt;
      track_idx   <= idx_nxt;
      timer_clear <= clear_nxt;
      timer_count <= (nxt == PLAYING);
      playing     <= (nxt == PLAYING);
      adv_stop    <= adv_stop_nxt;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_playback_controller.sv
// tb/tb_playback_controller.sv - directed bench for playback_controller with LOOP=0 and LOOP=1
module tb_playback_controller;

  localparam logic [1:0] S_STOP = 2'd0, S_PLAY = 2'd1, S_PAUSE = 2'd2, S_ADV = 2'd3;

  typedef struct {
    logic       pp, st, nx, pv;
    logic [1:0] es;
    logic [1:0] ei;
    logic       et;
    logic       ec;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_play_pause = 1'b0, btn_stop = 1'b0, btn_next = 1'b0, btn_prev = 1'b0;

  logic [1:0]  st  [2];
  logic [1:0]  ti  [2];
  logic        tk  [2];
  logic        tcl [2];
  logic        tcn [2];
  logic        ply [2];
  logic [11:0] tm  [2];
  logic [11:0] len [2];
  logic [11:0] len_tab [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  playback_controller #(.TICK_DIV(4), .NUM_TRACKS(3), .LOOP(1'b0)) u_dut0 (
    .clk(clk), .reset(reset),
    .btn_play_pause(btn_play_pause), .btn_stop(btn_stop), .btn_next(btn_next), .btn_prev(btn_prev),
    .len_s0(len[0][3:0]), .len_s1(len[0][7:4]), .len_m0(len[0][11:8]),
    .tm_s0(tm[0][3:0]), .tm_s1(tm[0][7:4]), .tm_m0(tm[0][11:8]),
    .sec_tick(tk[0]), .timer_count(tcn[0]), .timer_clear(tcl[0]),
    .track_idx(ti[0]), .playing(ply[0]), .state(st[0])
  );

  playback_controller #(.TICK_DIV(4), .NUM_TRACKS(3), .LOOP(1'b1)) u_dut1 (
    .clk(clk), .reset(reset),
    .btn_play_pause(btn_play_pause), .btn_stop(btn_stop), .btn_next(btn_next), .btn_prev(btn_prev),
    .len_s0(len[1][3:0]), .len_s1(len[1][7:4]), .len_m0(len[1][11:8]),
    .tm_s0(tm[1][3:0]), .tm_s1(tm[1][7:4]), .tm_m0(tm[1][11:8]),
    .sec_tick(tk[1]), .timer_count(tcn[1]), .timer_clear(tcl[1]),
    .track_idx(ti[1]), .playing(ply[1]), .state(st[1])
  );

  function automatic logic [11:0] bcd_inc(input logic [11:0] t);
    logic [3:0] s0, s1, m0;
    s0 = t[3:0];
    s1 = t[7:4];
    m0 = t[11:8];
    if (s0 != 4'd9) s0 = s0 + 4'd1;
    else begin
      s0 = 4'd0;
      if (s1 != 4'd5) s1 = s1 + 4'd1;
      else begin
        s1 = 4'd0;
        m0 = (m0 == 4'd9) ? 4'd0 : m0 + 4'd1;
      end
    end
    return {m0, s1, s0};
  endfunction

  // Behavioural Timer and track ROM, one per DUT.
  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (tcl[d]) tm[d] <= 12'h000;
      else if (tk[d]) tm[d] <= bcd_inc(tm[d]);
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      case (ti[d])
        2'd0:    len[d] = len_tab[0];
        2'd1:    len[d] = len_tab[1];
        2'd2:    len[d] = len_tab[2];
        default: len[d] = 12'h000;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input int d, input logic [1:0] es, input logic [1:0] ei,
                         input logic et, input logic ec);
    chk($sformatf("%s.d%0d.state", tag, d), 32'(st[d]), 32'(es));
    chk($sformatf("%s.d%0d.track_idx", tag, d), 32'(ti[d]), 32'(ei));
    chk($sformatf("%s.d%0d.sec_tick", tag, d), 32'(tk[d]), 32'(et));
    chk($sformatf("%s.d%0d.timer_clear", tag, d), 32'(tcl[d]), 32'(ec));
    chk($sformatf("%s.d%0d.playing", tag, d), 32'(ply[d]), 32'(es == S_PLAY));
    chk($sformatf("%s.d%0d.timer_count", tag, d), 32'(tcn[d]), 32'(es == S_PLAY));
  endtask

  task automatic chk_both(input string tag, input logic [1:0] es, input logic [1:0] ei,
                          input logic et, input logic ec);
    chk_dut(tag, 0, es, ei, et, ec);
    chk_dut(tag, 1, es, ei, et, ec);
  endtask

  task automatic step(input logic pp, input logic sp, input logic nx, input logic pv);
    btn_play_pause = pp;
    btn_stop       = sp;
    btn_next       = nx;
    btn_prev       = pv;
    @(posedge clk);
    #1;
    btn_play_pause = 1'b0;
    btn_stop       = 1'b0;
    btn_next       = 1'b0;
    btn_prev       = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  vec_t tbl [40];

  initial begin
    for (int i = 0; i < 40; i++) begin
      tbl[i].pp = (i == 0) || (i == 25) || (i == 35);
      tbl[i].st = 1'b0;
      tbl[i].nx = 1'b0;
      tbl[i].pv = 1'b0;
      tbl[i].es = (i >= 25 && i < 35) ? S_PAUSE : S_PLAY;
      tbl[i].ei = 2'd0;
      tbl[i].et = (i > 0 && i <= 24 && (i % 4) == 0) || (i == 39);
      tbl[i].ec = 1'b0;
    end
    for (int k = 0; k < 3; k++) len_tab[k] = 12'h030;

    // asynchronous reset before any clock edge
    #3 reset = 1'b0;
    #1;
    chk_both("rst_async", S_STOP, 2'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_both("rst_release", S_STOP, 2'd0, 1'b0, 1'b1);

    // play, six ticks, pause ten cycles, resume
    for (int i = 0; i < 40; i++) begin
      step(tbl[i].pp, tbl[i].st, tbl[i].nx, tbl[i].pv);
      chk_both($sformatf("tbl[%0d]", i), tbl[i].es, tbl[i].ei, tbl[i].et, tbl[i].ec);
      if (i == 25) chk("pause_time", 32'(tm[0]), 32'h006);
    end
    step(0, 0, 0, 0);
    chk("resume_time", 32'(tm[0]), 32'h007);

    // zero-length track ends on the first PLAYING cycle
    do_reset();
    len_tab[0] = 12'h000;
    step(1, 0, 0, 0);
    chk_both("zl_play", S_PLAY, 2'd0, 1'b0, 1'b0);
    step(0, 0, 0, 0);
    chk_both("zl_adv", S_ADV, 2'd1, 1'b0, 1'b1);
    step(0, 0, 0, 0);
    chk_both("zl_next", S_PLAY, 2'd1, 1'b0, 1'b0);
    step(0, 1, 0, 0);
    chk_both("zl_stop", S_STOP, 2'd1, 1'b0, 1'b1);

    // auto-advance through all tracks; LOOP=0 stops, LOOP=1 wraps
    do_reset();
    len_tab[0] = 12'h003;
    len_tab[1] = 12'h001;
    len_tab[2] = 12'h001;
    step(1, 0, 0, 0);
    for (int c = 1; c <= 29; c++) begin
      step(0, 0, 0, 0);
      case (c)
        12: chk_both("aa_tick12", S_PLAY, 2'd0, 1'b1, 1'b0);
        13: begin
          chk_both("aa_c13", S_PLAY, 2'd0, 1'b0, 1'b0);
          chk("aa_time13", 32'(tm[0]), 32'h003);
        end
        14: chk_both("aa_adv1", S_ADV, 2'd1, 1'b0, 1'b1);
        15: begin
          chk_both("aa_c15", S_PLAY, 2'd1, 1'b0, 1'b0);
          chk("aa_time15", 32'(tm[0]), 32'h000);
        end
        21: chk_both("aa_adv2", S_ADV, 2'd2, 1'b0, 1'b1);
        28: chk_both("aa_adv0", S_ADV, 2'd0, 1'b0, 1'b1);
        29: begin
          chk_dut("aa_end_noloop", 0, S_STOP, 2'd0, 1'b0, 1'b0);
          chk_dut("aa_end_loop", 1, S_PLAY, 2'd0, 1'b0, 1'b0);
        end
        default: ;
      endcase
    end

    // track selection and same-cycle button priority
    do_reset();
    for (int k = 0; k < 3; k++) len_tab[k] = 12'h030;
    step(0, 0, 1, 0); chk_both("st_next", S_STOP, 2'd1, 1'b0, 1'b1);
    step(0, 0, 0, 0); chk_both("st_idle", S_STOP, 2'd1, 1'b0, 1'b0);
    step(0, 0, 0, 1); chk_both("st_prev", S_STOP, 2'd0, 1'b0, 1'b1);
    step(0, 0, 0, 1); chk_both("st_prev_wrap", S_STOP, 2'd2, 1'b0, 1'b1);
    step(0, 0, 1, 0); chk_both("st_next_wrap", S_STOP, 2'd0, 1'b0, 1'b1);
    step(0, 0, 1, 1); chk_both("st_next_wins", S_STOP, 2'd1, 1'b0, 1'b1);
    step(1, 0, 0, 0); chk_both("pr_play", S_PLAY, 2'd1, 1'b0, 1'b0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 1, 0); chk_both("pr_stop_wins", S_STOP, 2'd1, 1'b0, 1'b1);
    step(0, 0, 0, 0); chk_both("pr_after", S_STOP, 2'd1, 1'b0, 1'b0);
    step(0, 0, 0, 1); chk_both("pl_sel0", S_STOP, 2'd0, 1'b0, 1'b1);
    step(1, 0, 0, 0); chk_both("pl_play", S_PLAY, 2'd0, 1'b0, 1'b0);
    step(0, 0, 0, 1); chk_both("pl_prev_adv", S_ADV, 2'd2, 1'b0, 1'b1);
    step(0, 0, 0, 0); chk_both("pl_prev_done", S_PLAY, 2'd2, 1'b0, 1'b0);
    step(0, 0, 1, 0); chk_both("pl_next_adv", S_ADV, 2'd0, 1'b0, 1'b1);
    step(0, 0, 0, 0); chk_both("pl_next_done", S_PLAY, 2'd0, 1'b0, 1'b0);
    step(1, 0, 0, 0); chk_both("pa_pause", S_PAUSE, 2'd0, 1'b0, 1'b0);
    step(0, 0, 1, 0); chk_both("pa_next", S_PAUSE, 2'd1, 1'b0, 1'b1);
    step(0, 1, 0, 0); chk_both("pa_stop", S_STOP, 2'd1, 1'b0, 1'b1);

    // reset dropped mid-count on track 1
    do_reset();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_both("mr_before", S_PLAY, 2'd1, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk_both("mr_async", S_STOP, 2'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 0, 0);
      chk_both($sformatf("mr_idle%0d", c), S_STOP, 2'd0, 1'b0, 1'b0);
    end
    step(1, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      step(0, 0, 0, 0);
      chk_both($sformatf("mr_replay%0d", c), S_PLAY, 2'd0, c == 4, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
